toggle_pulse_merger: RTL

- Clocked, buffered two-input pulse merger. It is the converging counterpart of the pulse splitter cell: two toggle-encoded pulse streams combine into one toggle-encoded output stream.
- Toggle encoding: every level change on a line is one pulse, either edge.
- Unlike an asynchronous merger, near-simultaneous pulses are not lost. They are counted and replayed, respecting a minimum output spacing.
- Sits at the boundary where RSFQ behavioural models feed synchronous test/verification logic.

---
 rtl/toggle_pkg.sv | 17 +
 rtl/toggle_edge_detect.sv | 20 ++
 rtl/toggle_pulse_merger.sv | 100 ++++++++++
 3 files changed

// File: rtl/toggle_pkg.sv
// Shared types and helpers for the toggle-encoded pulse merger.
// The saturating add works on plain integers so every counter width can use it.
package toggle_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int GAP_W = 4;

  // cur + inc - dec, clamped to max_val; callers only subtract when cur + inc > 0.
  function automatic int unsigned sat_add(input int unsigned cur, input int unsigned inc,
                                          input int unsigned dec, input int unsigned max_val);
    int unsigned s;
    s = cur + inc - dec;
    return (s > max_val) ? max_val : s;
  endfunction

endpackage

// File: rtl/toggle_edge_detect.sv
// Toggle detector: one pulse per level change of d while en is high.
// With en low the registered copy still tracks d, so those toggles are absorbed.
module toggle_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic ev
);

  logic d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_reg <= 1'b0;
    else        d_reg <= d;
  end

  assign ev = en & (d ^ d_reg);

endmodule

// File: rtl/toggle_pulse_merger.sv
// Merges two toggle-encoded pulse streams into one, buffering coincident pulses
// in a saturating counter and replaying them no closer than MIN_GAP cycles apart.
module toggle_pulse_merger
  import toggle_pkg::*;
#(
  parameter int CNT_W       = 3,
  parameter int MIN_GAP     = 1,
  parameter int INIT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             q,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int MAX_PEND = 2**CNT_W - 1;
  localparam int SUM_W    = CNT_W + 2;
  localparam int INIT_W   = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST  = INIT_W'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(MIN_GAP - 1);

  state_t             state_reg, state_next;
  logic [INIT_W-1:0]  init_cnt_reg, init_cnt_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [CNT_W-1:0]   pending_reg, pending_next;
  logic               q_reg, q_next;
  logic               ovf_reg, ovf_next;

  logic               run;
  logic [1:0]         in_vec, ev_vec;
  logic [1:0]         events;
  logic [SUM_W-1:0]   sum_wide, nxt_wide;
  logic               emit;

  assign run    = (state_reg == RUN);
  assign in_vec = {b, a};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_det
      toggle_edge_detect u_det (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .d     (in_vec[gi]),
        .ev    (ev_vec[gi])
      );
    end
  endgenerate

  assign events = {1'b0, ev_vec[0]} + {1'b0, ev_vec[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
      gap_reg      <= '0;
      pending_reg  <= '0;
      q_reg        <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      gap_reg      <= gap_next;
      pending_reg  <= pending_next;
      q_reg        <= q_next;
      ovf_reg      <= ovf_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    gap_next      = gap_reg;
    sum_wide      = {2'b00, pending_reg} + SUM_W'(events);
    emit          = run && (sum_wide != '0) && (gap_reg == '0);
    nxt_wide      = sum_wide - SUM_W'(emit);
    pending_next  = CNT_W'(sat_add(32'(pending_reg), 32'(events), 32'(emit), MAX_PEND));
    ovf_next      = ovf_reg | (nxt_wide > SUM_W'(MAX_PEND));
    q_next        = q_reg ^ emit;

    // The init counter freezes once RUN is reached rather than wrapping.
    if (state_reg == INIT) begin
      if (INIT_CYCLES == 0 || init_cnt_reg == INIT_LAST) state_next = RUN;
      else                                               init_cnt_next = init_cnt_reg + 1'b1;
    end

    if (emit)                gap_next = GAP_RELOAD;
    else if (gap_reg != '0)  gap_next = gap_reg - 1'b1;
  end

  assign q        = q_reg;
  assign pending  = pending_reg;
  assign busy     = (pending_reg != '0);
  assign overflow = ovf_reg;

endmodule
